// File: rtl/fetch_unit_pkg.sv
// Processor-wide shared definitions used by the fetch, memory and decode stages.
package fetch_unit_pkg;

    // Default datapath widths shared across stages (256-word unified memory).
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    // Opcode field location inside an instruction word.
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;

    // Opcode value that identifies a halt instruction.
    localparam logic [5:0] OPC_HALT = 6'h3F;

    // Fetch stage operating state.
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC selection: branch redirect, hold, or sequential increment (wraps modulo 2^ADDR_W).
module fetch_pc_sel
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              hold,
    output logic [ADDR_W-1:0] next_pc
);

    // Redirect wins over hold; otherwise advance by one word.
    always_comb begin
        next_pc = pc + 1'b1;
        if (branch_taken) begin
            next_pc = branch_target;
        end else if (hold) begin
            next_pc = pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the memory address, captures the returned word into
// the instruction register, and handles branch flush, decode stall and HALT/resume.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              ADDR_W      = DEF_ADDR_W,
    parameter int              DATA_W      = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [5:0]      HALT_OPCODE = OPC_HALT
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] inst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              resume,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    output logic              halted
);

    fetch_state_t      state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;
    logic [DATA_W-1:0] ir_reg;
    logic [ADDR_W-1:0] ir_pc_reg;
    logic              ir_valid_reg;
    logic              pc_hold;
    logic              inst_is_halt;

    // PC holds while halted (no fetching) or while decode is stalled.
    assign pc_hold      = (state_reg == HALT) || stall;
    assign inst_is_halt = (inst[OPC_HI:OPC_LO] == HALT_OPCODE);

    fetch_pc_sel #(
        .ADDR_W(ADDR_W)
    ) u_pc_sel (
        .pc            (pc_reg),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .hold          (pc_hold),
        .next_pc       (pc_next)
    );

    // Fetch FSM, PC and instruction register; all outputs come straight from these flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= RUN;
            pc_reg       <= RESET_PC;
            ir_reg       <= '0;
            ir_pc_reg    <= '0;
            ir_valid_reg <= 1'b0;
        end else begin
            pc_reg <= pc_next;
            case (state_reg)
                RUN: begin
                    if (branch_taken) begin
                        // Flush the wrong-path word; a halt opcode on inst is discarded too.
                        ir_reg       <= '0;
                        ir_valid_reg <= 1'b0;
                    end else if (!stall) begin
                        ir_reg       <= inst;
                        ir_pc_reg    <= pc_reg;
                        ir_valid_reg <= 1'b1;
                        if (inst_is_halt) begin
                            state_reg <= HALT;
                        end
                    end
                end
                HALT: begin
                    // The halt word stays visible only until decode has taken it once.
                    if (branch_taken || !stall) begin
                        ir_valid_reg <= 1'b0;
                    end
                    // Resume only re-enables fetching; the first fetch happens next edge.
                    if (resume) begin
                        state_reg <= RUN;
                    end
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

    assign pc       = pc_reg;
    assign ir       = ir_reg;
    assign ir_pc    = ir_pc_reg;
    assign ir_valid = ir_valid_reg;
    assign halted   = (state_reg == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic,
// compared against a behavioural model of the fetch stage kept in the bench.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  pc;
    logic [31:0] inst;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        resume;
    logic [31:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        halted;

    logic [31:0] mem [256];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Behavioural model state
    int          m_pc;
    logic [31:0] m_ir;
    int          m_ir_pc;
    logic        m_valid;
    logic        m_halted;

    assign inst = mem[pc];

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .inst          (inst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .resume        (resume),
        .ir            (ir),
        .ir_pc         (ir_pc),
        .ir_valid      (ir_valid),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc     = 0;
        m_ir     = 32'h0;
        m_ir_pc  = 0;
        m_valid  = 1'b0;
        m_halted = 1'b0;
    endtask

    // Apply one clock edge of the fetch rules to the model, then advance the DUT.
    task automatic advance();
        logic [31:0] w;
        if (m_halted) begin
            if (branch_taken) begin
                m_pc    = int'(branch_target);
                m_valid = 1'b0;
            end else if (!stall) begin
                m_valid = 1'b0;
            end
            if (resume) m_halted = 1'b0;
        end else if (branch_taken) begin
            m_pc    = int'(branch_target);
            m_ir    = 32'h0;
            m_valid = 1'b0;
        end else if (!stall) begin
            w       = mem[m_pc];
            m_ir    = w;
            m_ir_pc = m_pc;
            m_valid = 1'b1;
            m_pc    = (m_pc + 1) % 256;
            if (w[31:26] == 6'h3F) m_halted = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d st=%0b br=%0b tgt=%02h rs=%0b | pc=%02h ir=%08h ir_pc=%02h v=%0b h=%0b",
                 cyc, stall, branch_taken, branch_target, resume, pc, ir, ir_pc, ir_valid, halted);
    endtask

    task automatic drive(input logic s, input logic b, input logic [7:0] t, input logic r);
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        resume        = r;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (pc !== 8'h00 || ir !== 32'h0 || ir_pc !== 8'h00 || ir_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%h ir=%h ir_pc=%h v=%b h=%b required all zero", pc, ir, ir_pc, ir_valid, halted);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        advance();
        checks++;
        if (pc !== 8'd1 || ir !== 32'h11111111 || ir_pc !== 8'd0 || ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL seq_first: pc=%h ir=%h ir_pc=%h v=%b required 01 11111111 00 1", pc, ir, ir_pc, ir_valid);
        end
        advance();
        checks++;
        if (pc !== 8'd2 || ir !== 32'h22222222 || ir_pc !== 8'd1 || ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL seq_second: pc=%h ir=%h ir_pc=%h v=%b required 02 22222222 01 1", pc, ir, ir_pc, ir_valid);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            advance();
            checks++;
            if (pc !== 8'd2 || ir !== 32'h22222222 || ir_pc !== 8'd1 || ir_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: pc=%h ir=%h ir_pc=%h v=%b required 02 22222222 01 1", i, pc, ir, ir_pc, ir_valid);
            end
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        advance();
        checks++;
        if (pc !== 8'd3 || ir !== mem[2] || ir_pc !== 8'd2 || ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: pc=%h ir=%h ir_pc=%h v=%b required 03 %h 02 1", pc, ir, ir_pc, ir_valid, mem[2]);
        end
    endtask

    task automatic test_halt();
        advance();
        checks++;
        if (ir !== 32'hFC000000 || ir_valid !== 1'b1 || halted !== 1'b1 || pc !== 8'd4) begin
            errors++;
            $display("FAIL halt_enter: ir=%h v=%b h=%b pc=%h required FC000000 1 1 04", ir, ir_valid, halted, pc);
        end
        for (int i = 0; i < 2; i++) begin
            advance();
            checks++;
            if (ir_valid !== 1'b0 || halted !== 1'b1 || pc !== 8'd4) begin
                errors++;
                $display("FAIL halt_idle[%0d]: v=%b h=%b pc=%h required 0 1 04", i, ir_valid, halted, pc);
            end
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        advance();
        checks++;
        if (halted !== 1'b0 || ir_valid !== 1'b0 || pc !== 8'd4) begin
            errors++;
            $display("FAIL halt_resume: h=%b v=%b pc=%h required 0 0 04", halted, ir_valid, pc);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        advance();
        checks++;
        if (ir !== mem[4] || ir_pc !== 8'd4 || ir_valid !== 1'b1 || pc !== 8'd5) begin
            errors++;
            $display("FAIL halt_refetch: ir=%h ir_pc=%h v=%b pc=%h required %h 04 1 05", ir, ir_pc, ir_valid, pc, mem[4]);
        end
    endtask

    // Branch while stalled and while a halt word sits at pc: the branch must win.
    task automatic test_branch();
        drive(1'b1, 1'b1, 8'h40, 1'b0);
        advance();
        checks++;
        if (pc !== 8'h40 || ir_valid !== 1'b0 || ir !== 32'h0 || ir_pc !== 8'd4 || halted !== 1'b0) begin
            errors++;
            $display("FAIL branch_flush: pc=%h v=%b ir=%h ir_pc=%h h=%b required 40 0 0 04 0", pc, ir_valid, ir, ir_pc, halted);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        advance();
        checks++;
        if (ir !== mem[8'h40] || ir_pc !== 8'h40 || ir_valid !== 1'b1 || pc !== 8'h41) begin
            errors++;
            $display("FAIL branch_fetch: ir=%h ir_pc=%h v=%b pc=%h required %h 40 1 41", ir, ir_pc, ir_valid, pc, mem[8'h40]);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b1, 8'hFF, 1'b0);
        advance();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        advance();
        checks++;
        if (ir_pc !== 8'hFF || pc !== 8'h00 || ir !== mem[255] || ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_ff: ir_pc=%h pc=%h ir=%h v=%b required FF 00 %h 1", ir_pc, pc, ir, ir_valid, mem[255]);
        end
        advance();
        checks++;
        if (ir_pc !== 8'h00 || pc !== 8'h01 || ir !== mem[0] || ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_00: ir_pc=%h pc=%h ir=%h v=%b required 00 01 %h 1", ir_pc, pc, ir, ir_valid, mem[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        for (int a = 0; a < 256; a++) begin
            w = $urandom;
            if ($urandom_range(0, 15) == 0) w[31:26] = 6'h3F;
            else if (w[31:26] == 6'h3F) w[31:26] = 6'h00;
            mem[a] = w;
        end
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
                  8'($urandom_range(0, 255)), $urandom_range(0, 4) == 0);
            advance();
            checks++;
            if (pc !== 8'(m_pc) || ir !== m_ir || ir_pc !== 8'(m_ir_pc) || ir_valid !== m_valid || halted !== m_halted) begin
                errors++;
                $display("FAIL random[%0d]: pc=%h ir=%h ir_pc=%h v=%b h=%b required %h %h %h %b %b",
                         i, pc, ir, ir_pc, ir_valid, halted, 8'(m_pc), m_ir, 8'(m_ir_pc), m_valid, m_halted);
            end
        end
    endtask

    // Enter HALT with stall held, then hit reset between clock edges.
    task automatic test_async_reset();
        mem[8'h80] = 32'hFC0000AA;
        mem[0]     = 32'h11111111;
        drive(1'b0, 1'b1, 8'h80, 1'b1);
        advance();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        advance();
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        advance();
        advance();
        checks++;
        if (halted !== 1'b1 || ir !== 32'hFC0000AA || ir_valid !== 1'b1 || pc !== 8'h81) begin
            errors++;
            $display("FAIL areset_pre: h=%b ir=%h v=%b pc=%h required 1 FC0000AA 1 81", halted, ir, ir_valid, pc);
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (pc !== 8'h00 || ir !== 32'h0 || ir_pc !== 8'h00 || ir_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL areset_now: pc=%h ir=%h ir_pc=%h v=%b h=%b required all zero", pc, ir, ir_pc, ir_valid, halted);
        end
        #3 rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        advance();
        checks++;
        if (pc !== 8'h01 || ir !== 32'h11111111 || ir_pc !== 8'h00 || ir_valid !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL areset_after: pc=%h ir=%h ir_pc=%h v=%b h=%b required 01 11111111 00 1 0", pc, ir, ir_pc, ir_valid, halted);
        end
    endtask

    initial begin
        logic [31:0] w;
        for (int a = 0; a < 256; a++) begin
            w = $urandom;
            w[31] = 1'b0;
            mem[a] = w;
        end
        mem[0]     = 32'h11111111;
        mem[1]     = 32'h22222222;
        mem[3]     = 32'hFC000000;
        mem[5]     = 32'hFC000055;
        mem[8'hFF] = 32'h0BADF00D;

        test_reset();
        test_sequential();
        test_stall();
        test_halt();
        test_branch();
        test_wrap();
        test_random();
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard upper bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
